mem_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one mem_unit (single-port synchronous RAM, en/wr/addr/data interface) between two requesters.
- Port m0 is the instruction-fetch side; port m1 is the load/store side.
- Issues at most one access per cycle to the memory.
- Tracks in-flight accesses in a MEM_LAT-deep tag pipeline and routes each response (read data or write ack) back to the port that issued it.

---
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one single-port synchronous RAM.
// Responses are routed back to the issuing port through a MEM_LAT-deep tag pipeline.
package mem_arbiter_pkg;
    typedef struct packed {
        logic valid;
        logic owner;
    } tag_t;
endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AW      = 11,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          m0_req_i,
    input  logic          m0_wr_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_data_i,
    output logic          m0_gnt_o,
    output logic          m0_rvalid_o,
    output logic [DW-1:0] m0_data_o,
    input  logic          m1_req_i,
    input  logic          m1_wr_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_data_i,
    output logic          m1_gnt_o,
    output logic          m1_rvalid_o,
    output logic [DW-1:0] m1_data_o,
    output logic          mem_en_o,
    output logic          mem_wr_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_data_o,
    input  logic [DW-1:0] mem_data_i
);

    localparam int unsigned LAST = MEM_LAT - 1;

    if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
        $error("mem_arbiter: MEM_LAT must be in 1..4");
    end

    logic ptr_q;
    logic gnt0_c;
    logic gnt1_c;
    logic any_gnt_c;
    tag_t stage_q [MEM_LAT];

    // Grant logic; the pointer only matters when both ports contend.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (rst_n_i) begin
            if (m0_req_i && (!m1_req_i || !ptr_q)) begin
                gnt0_c = 1'b1;
            end else if (m1_req_i) begin
                gnt1_c = 1'b1;
            end
        end
    end

    assign any_gnt_c = gnt0_c | gnt1_c;
    assign m0_gnt_o  = gnt0_c;
    assign m1_gnt_o  = gnt1_c;

    // Pointer moves to the port that lost (or was idle) on every grant.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q <= 1'b0;
        end else if (any_gnt_c) begin
            ptr_q <= gnt0_c;
        end
    end

    // Memory command mux; idle cycles park on m0's address/data.
    always_comb begin
        mem_en_o   = any_gnt_c;
        mem_wr_o   = 1'b0;
        mem_addr_o = m0_addr_i;
        mem_data_o = m0_data_i;
        if (gnt1_c) begin
            mem_wr_o   = m1_wr_i;
            mem_addr_o = m1_addr_i;
            mem_data_o = m1_data_i;
        end else if (gnt0_c) begin
            mem_wr_o   = m0_wr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stage_q[0] <= '0;
        end else begin
            stage_q[0] <= '{valid: any_gnt_c, owner: gnt1_c};
        end
    end

    for (genvar i = 1; i < MEM_LAT; i++) begin : g_stage
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign m0_rvalid_o = stage_q[LAST].valid & ~stage_q[LAST].owner;
    assign m1_rvalid_o = stage_q[LAST].valid &  stage_q[LAST].owner;
    assign m0_data_o   = mem_data_i;
    assign m1_data_o   = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance "a" at MEM_LAT=1, instance "b" at MEM_LAT=2,
// each backed by a small behavioural RAM with a backdoor preload port.
module tb_mem_arbiter;

    logic clk;
    int   vecs;
    int   errs;

    logic        a_rst_n, a_m0_req, a_m0_wr, a_m0_gnt, a_m0_rvalid;
    logic        a_m1_req, a_m1_wr, a_m1_gnt, a_m1_rvalid;
    logic [10:0] a_m0_addr, a_m1_addr, a_mem_addr;
    logic [31:0] a_m0_wdata, a_m1_wdata, a_m0_data, a_m1_data;
    logic        a_mem_en, a_mem_wr;
    logic [31:0] a_mem_wdata, a_mem_rdata;

    logic        b_rst_n, b_m0_req, b_m0_wr, b_m0_gnt, b_m0_rvalid;
    logic        b_m1_req, b_m1_wr, b_m1_gnt, b_m1_rvalid;
    logic [10:0] b_m0_addr, b_m1_addr, b_mem_addr;
    logic [31:0] b_m0_wdata, b_m1_wdata, b_m0_data, b_m1_data;
    logic        b_mem_en, b_mem_wr;
    logic [31:0] b_mem_wdata, b_mem_rdata;

    logic        a_bd_we, b_bd_we;
    logic [10:0] a_bd_addr, b_bd_addr;
    logic [31:0] a_bd_data, b_bd_data;
    logic [31:0] a_mem [2048];
    logic [31:0] b_mem [2048];
    logic [31:0] a_q, b_q0, b_q1;

    mem_arbiter #(.AW(11), .DW(32), .MEM_LAT(1)) dut_a (
        .clk_i(clk), .rst_n_i(a_rst_n),
        .m0_req_i(a_m0_req), .m0_wr_i(a_m0_wr), .m0_addr_i(a_m0_addr), .m0_data_i(a_m0_wdata),
        .m0_gnt_o(a_m0_gnt), .m0_rvalid_o(a_m0_rvalid), .m0_data_o(a_m0_data),
        .m1_req_i(a_m1_req), .m1_wr_i(a_m1_wr), .m1_addr_i(a_m1_addr), .m1_data_i(a_m1_wdata),
        .m1_gnt_o(a_m1_gnt), .m1_rvalid_o(a_m1_rvalid), .m1_data_o(a_m1_data),
        .mem_en_o(a_mem_en), .mem_wr_o(a_mem_wr), .mem_addr_o(a_mem_addr),
        .mem_data_o(a_mem_wdata), .mem_data_i(a_mem_rdata)
    );

    mem_arbiter #(.AW(11), .DW(32), .MEM_LAT(2)) dut_b (
        .clk_i(clk), .rst_n_i(b_rst_n),
        .m0_req_i(b_m0_req), .m0_wr_i(b_m0_wr), .m0_addr_i(b_m0_addr), .m0_data_i(b_m0_wdata),
        .m0_gnt_o(b_m0_gnt), .m0_rvalid_o(b_m0_rvalid), .m0_data_o(b_m0_data),
        .m1_req_i(b_m1_req), .m1_wr_i(b_m1_wr), .m1_addr_i(b_m1_addr), .m1_data_i(b_m1_wdata),
        .m1_gnt_o(b_m1_gnt), .m1_rvalid_o(b_m1_rvalid), .m1_data_o(b_m1_data),
        .mem_en_o(b_mem_en), .mem_wr_o(b_mem_wr), .mem_addr_o(b_mem_addr),
        .mem_data_o(b_mem_wdata), .mem_data_i(b_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAMs; read data appears MEM_LAT cycles after the enable edge.
    always @(posedge clk) begin
        if (a_bd_we) a_mem[a_bd_addr] <= a_bd_data;
        else if (a_mem_en) begin
            if (a_mem_wr) a_mem[a_mem_addr] <= a_mem_wdata;
            else a_q <= a_mem[a_mem_addr];
        end
    end
    assign a_mem_rdata = a_q;

    always @(posedge clk) begin
        if (b_bd_we) b_mem[b_bd_addr] <= b_bd_data;
        else if (b_mem_en) begin
            if (b_mem_wr) b_mem[b_mem_addr] <= b_mem_wdata;
            else b_q0 <= b_mem[b_mem_addr];
        end
        b_q1 <= b_q0;
    end
    assign b_mem_rdata = b_q1;

    task automatic a_poke(input logic [10:0] addr, input logic [31:0] data);
        @(negedge clk);
        a_bd_we = 1'b1; a_bd_addr = addr; a_bd_data = data;
        @(negedge clk);
        a_bd_we = 1'b0;
    endtask

    task automatic b_poke(input logic [10:0] addr, input logic [31:0] data);
        @(negedge clk);
        b_bd_we = 1'b1; b_bd_addr = addr; b_bd_data = data;
        @(negedge clk);
        b_bd_we = 1'b0;
    endtask

    task automatic a_reset();
        @(negedge clk);
        a_rst_n = 1'b0;
        @(negedge clk);
        a_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        a_m0_req = 1'b1; a_m1_req = 1'b1; b_m0_req = 1'b1;
        #1;
        vecs++; if (a_m0_gnt !== 1'b0) begin errs++; $display("FAIL rst_m0_gnt: got %b want 0", a_m0_gnt); end
        vecs++; if (a_m1_gnt !== 1'b0) begin errs++; $display("FAIL rst_m1_gnt: got %b want 0", a_m1_gnt); end
        vecs++; if (a_mem_en !== 1'b0) begin errs++; $display("FAIL rst_mem_en: got %b want 0", a_mem_en); end
        vecs++; if (b_mem_en !== 1'b0) begin errs++; $display("FAIL rst_b_mem_en: got %b want 0", b_mem_en); end
        vecs++; if ({a_m0_rvalid, a_m1_rvalid, b_m0_rvalid, b_m1_rvalid} !== 4'b0000) begin
            errs++; $display("FAIL rst_rvalid: got %b want 0000", {a_m0_rvalid, a_m1_rvalid, b_m0_rvalid, b_m1_rvalid});
        end
        a_m0_req = 1'b0; a_m1_req = 1'b0; b_m0_req = 1'b0;
        @(negedge clk);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
    endtask

    task automatic test_write();
        @(negedge clk);
        a_m0_req = 1'b1; a_m0_wr = 1'b1; a_m0_addr = 11'h003; a_m0_wdata = 32'h0000_00FF;
        #1;
        vecs++; if (a_m0_gnt !== 1'b1) begin errs++; $display("FAIL wr_m0_gnt: got %b want 1", a_m0_gnt); end
        vecs++; if (a_m1_gnt !== 1'b0) begin errs++; $display("FAIL wr_m1_gnt: got %b want 0", a_m1_gnt); end
        vecs++; if ({a_mem_en, a_mem_wr} !== 2'b11) begin errs++; $display("FAIL wr_mem_en_wr: got %b want 11", {a_mem_en, a_mem_wr}); end
        vecs++; if (a_mem_addr !== 11'h003) begin errs++; $display("FAIL wr_mem_addr: got %h want 003", a_mem_addr); end
        vecs++; if (a_mem_wdata !== 32'h0000_00FF) begin errs++; $display("FAIL wr_mem_data: got %h want 000000ff", a_mem_wdata); end
        @(negedge clk);
        a_m0_req = 1'b0; a_m0_wr = 1'b0;
        #1;
        vecs++; if (a_m0_rvalid !== 1'b1) begin errs++; $display("FAIL wr_ack: got %b want 1", a_m0_rvalid); end
        vecs++; if (a_m1_rvalid !== 1'b0) begin errs++; $display("FAIL wr_m1_rvalid: got %b want 0", a_m1_rvalid); end
        @(negedge clk);
        #1;
        vecs++; if (a_m0_rvalid !== 1'b0) begin errs++; $display("FAIL wr_ack_single: got %b want 0", a_m0_rvalid); end
    endtask

    task automatic test_read_back();
        @(negedge clk);
        a_m1_req = 1'b1; a_m1_wr = 1'b0; a_m1_addr = 11'h003;
        #1;
        vecs++; if (a_m1_gnt !== 1'b1) begin errs++; $display("FAIL rd_m1_gnt: got %b want 1", a_m1_gnt); end
        vecs++; if (a_m0_gnt !== 1'b0) begin errs++; $display("FAIL rd_m0_gnt: got %b want 0", a_m0_gnt); end
        vecs++; if (a_mem_wr !== 1'b0) begin errs++; $display("FAIL rd_mem_wr: got %b want 0", a_mem_wr); end
        @(negedge clk);
        a_m1_req = 1'b0;
        #1;
        vecs++; if (a_m1_rvalid !== 1'b1) begin errs++; $display("FAIL rd_m1_rvalid: got %b want 1", a_m1_rvalid); end
        vecs++; if (a_m1_data !== 32'h0000_00FF) begin errs++; $display("FAIL rd_m1_data: got %h want 000000ff", a_m1_data); end
        vecs++; if (a_m0_rvalid !== 1'b0) begin errs++; $display("FAIL rd_m0_rvalid: got %b want 0", a_m0_rvalid); end
    endtask

    task automatic test_contention();
        logic [4:0]  exp_g0;
        logic [4:0]  exp_v0;
        logic [4:0]  exp_v1;
        logic [10:0] exp_addr [5];
        logic [31:0] exp_data [5];
        exp_g0 = 5'b00101;  exp_v0 = 5'b01010;  exp_v1 = 5'b10100;
        exp_addr = '{11'h010, 11'h020, 11'h010, 11'h020, 11'h000};
        exp_data = '{32'h0, 32'h0000_1010, 32'h0000_2020, 32'h0000_1010, 32'h0000_2020};
        a_poke(11'h010, 32'h0000_1010);
        a_poke(11'h020, 32'h0000_2020);
        a_reset();
        a_m0_addr = 11'h010; a_m1_addr = 11'h020; a_m0_wr = 1'b0; a_m1_wr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a_m0_req = (k < 4); a_m1_req = (k < 4);
            #1;
            if (k < 4) begin
                vecs++; if ({a_m0_gnt, a_m1_gnt} !== {exp_g0[k], ~exp_g0[k]}) begin
                    errs++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, {a_m0_gnt, a_m1_gnt}, {exp_g0[k], ~exp_g0[k]});
                end
                vecs++; if (a_mem_addr !== exp_addr[k]) begin
                    errs++; $display("FAIL rr_addr[%0d]: got %h want %h", k, a_mem_addr, exp_addr[k]);
                end
            end
            vecs++; if ({a_m0_rvalid, a_m1_rvalid} !== {exp_v0[k], exp_v1[k]}) begin
                errs++; $display("FAIL rr_rvalid[%0d]: got %b want %b", k, {a_m0_rvalid, a_m1_rvalid}, {exp_v0[k], exp_v1[k]});
            end
            if (k > 0) begin
                vecs++; if (a_m0_data !== exp_data[k]) begin
                    errs++; $display("FAIL rr_data[%0d]: got %h want %h", k, a_m0_data, exp_data[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_data [3];
        exp_data = '{32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3};
        b_poke(11'h001, 32'h0000_00A1);
        b_poke(11'h002, 32'h0000_00A2);
        b_poke(11'h003, 32'h0000_00A3);
        b_m0_wr = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            b_m0_req = (k < 3);
            b_m0_addr = 11'(k + 1);
            #1;
            if (k < 3) begin
                vecs++; if (b_m0_gnt !== 1'b1) begin errs++; $display("FAIL b2b_gnt[%0d]: got %b want 1", k, b_m0_gnt); end
            end
            vecs++; if (b_m0_rvalid !== (k >= 2 && k <= 4)) begin
                errs++; $display("FAIL b2b_rvalid[%0d]: got %b want %b", k, b_m0_rvalid, (k >= 2 && k <= 4));
            end
            vecs++; if (b_m1_rvalid !== 1'b0) begin errs++; $display("FAIL b2b_m1_rvalid[%0d]: got %b want 0", k, b_m1_rvalid); end
            if (k >= 2 && k <= 4) begin
                vecs++; if (b_m0_data !== exp_data[k-2]) begin
                    errs++; $display("FAIL b2b_data[%0d]: got %h want %h", k, b_m0_data, exp_data[k-2]);
                end
                vecs++; if (b_m1_data !== exp_data[k-2]) begin
                    errs++; $display("FAIL b2b_m1_data[%0d]: got %h want %h", k, b_m1_data, exp_data[k-2]);
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        b_m1_req = 1'b1; b_m1_wr = 1'b0; b_m1_addr = 11'h001;
        #1;
        vecs++; if (b_m1_gnt !== 1'b1) begin errs++; $display("FAIL rif_m1_gnt: got %b want 1", b_m1_gnt); end
        @(negedge clk);
        b_m1_req = 1'b0; b_rst_n = 1'b0;
        @(negedge clk);
        b_rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            vecs++; if ({b_m0_rvalid, b_m1_rvalid} !== 2'b00) begin
                errs++; $display("FAIL rif_rvalid[%0d]: got %b want 00", k, {b_m0_rvalid, b_m1_rvalid});
            end
            @(negedge clk);
        end
        b_m0_req = 1'b1; b_m1_req = 1'b1; b_m0_addr = 11'h002;
        #1;
        vecs++; if ({b_m0_gnt, b_m1_gnt} !== 2'b10) begin errs++; $display("FAIL rif_ptr: got %b want 10", {b_m0_gnt, b_m1_gnt}); end
        @(negedge clk);
        b_m0_req = 1'b0;
        #1;
        vecs++; if ({b_m0_gnt, b_m1_gnt} !== 2'b01) begin errs++; $display("FAIL rif_next: got %b want 01", {b_m0_gnt, b_m1_gnt}); end
        @(negedge clk);
        b_m1_req = 1'b0;
    endtask

    task automatic test_lone_requester();
        a_reset();
        @(negedge clk);
        a_m1_req = 1'b1; a_m1_wr = 1'b1; a_m1_addr = 11'h055; a_m1_wdata = 32'h1234_5678;
        #1;
        vecs++; if ({a_m0_gnt, a_m1_gnt} !== 2'b01) begin errs++; $display("FAIL lone_gnt: got %b want 01", {a_m0_gnt, a_m1_gnt}); end
        vecs++; if (a_mem_addr !== 11'h055) begin errs++; $display("FAIL lone_addr: got %h want 055", a_mem_addr); end
        vecs++; if (a_mem_wdata !== 32'h1234_5678) begin errs++; $display("FAIL lone_data: got %h want 12345678", a_mem_wdata); end
        @(negedge clk);
        a_m1_req = 1'b0; a_m1_wr = 1'b0; a_m0_addr = 11'h07F;
        #1;
        vecs++; if ({a_mem_en, a_mem_wr, a_m0_gnt, a_m1_gnt} !== 4'b0000) begin
            errs++; $display("FAIL idle_drive: got %b want 0000", {a_mem_en, a_mem_wr, a_m0_gnt, a_m1_gnt});
        end
        vecs++; if (a_mem_addr !== 11'h07F) begin errs++; $display("FAIL idle_addr: got %h want 07f", a_mem_addr); end
        vecs++; if (a_m1_rvalid !== 1'b1) begin errs++; $display("FAIL lone_ack: got %b want 1", a_m1_rvalid); end
        @(negedge clk);
        a_m0_req = 1'b1; a_m1_req = 1'b1; a_m0_wr = 1'b0;
        #1;
        vecs++; if ({a_m0_gnt, a_m1_gnt} !== 2'b10) begin errs++; $display("FAIL lone_contend: got %b want 10", {a_m0_gnt, a_m1_gnt}); end
        @(negedge clk);
        a_m0_req = 1'b0;
        #1;
        vecs++; if ({a_m0_gnt, a_m1_gnt} !== 2'b01) begin errs++; $display("FAIL lone_alt: got %b want 01", {a_m0_gnt, a_m1_gnt}); end
        vecs++; if (a_m0_rvalid !== 1'b1) begin errs++; $display("FAIL lone_m0_rvalid: got %b want 1", a_m0_rvalid); end
        @(negedge clk);
        a_m1_req = 1'b0;
        #1;
        vecs++; if (a_m1_rvalid !== 1'b1) begin errs++; $display("FAIL raw_rvalid: got %b want 1", a_m1_rvalid); end
        vecs++; if (a_m1_data !== 32'h1234_5678) begin errs++; $display("FAIL raw_data: got %h want 12345678", a_m1_data); end
    endtask

    initial begin
        vecs = 0; errs = 0;
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_m0_req = 0; a_m0_wr = 0; a_m0_addr = '0; a_m0_wdata = '0;
        a_m1_req = 0; a_m1_wr = 0; a_m1_addr = '0; a_m1_wdata = '0;
        b_m0_req = 0; b_m0_wr = 0; b_m0_addr = '0; b_m0_wdata = '0;
        b_m1_req = 0; b_m1_wr = 0; b_m1_addr = '0; b_m1_wdata = '0;
        a_bd_we = 0; a_bd_addr = '0; a_bd_data = '0;
        b_bd_we = 0; b_bd_addr = '0; b_bd_data = '0;
        test_reset();
        test_write();
        test_read_back();
        test_contention();
        test_back_to_back();
        test_reset_inflight();
        test_lone_requester();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
